// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, column
// strobe patterns, key legend table and the row priority helper.
package keypad_pkg;

    // FSM encoding
    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    // Column strobes, active-low one-hot; index 0 drives the MSB low
    localparam logic [3:0]      COLS_OFF = 4'b1111;
    localparam logic [3:0][3:0] COL_PAT  = {4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Key legend indexed by {row, col}
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,   // row 3
        4'hC, 4'h9, 4'h8, 4'h7,   // row 2
        4'hB, 4'h6, 4'h5, 4'h4,   // row 1
        4'hA, 4'h3, 4'h2, 4'h1    // row 0
    };

    function automatic logic [3:0] key_lookup(logic [1:0] row, logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

    // {hit, index} of the lowest-numbered pressed (low) row
    function automatic logic [2:0] first_pressed(logic [3:0] r);
        if (!r[0]) return 3'b100;
        if (!r[1]) return 3'b101;
        if (!r[2]) return 3'b110;
        if (!r[3]) return 3'b111;
        return 3'b000;
    endfunction

endpackage

// File: rtl/keypad_row_sampler.sv
// Row synchronizer and column-slot timer. beat marks the last clock of a
// slot; rows are only meaningful to the scanner on that clock.
module keypad_row_sampler #(
    parameter int SCAN_COUNTS = 100_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [3:0] rows,
    output logic [3:0] rows_sync,
    output logic       beat
);

    localparam int             SW   = (SCAN_COUNTS > 1) ? $clog2(SCAN_COUNTS) : 1;
    localparam logic [SW-1:0]  LAST = SW'(SCAN_COUNTS - 1);

    logic [3:0]    meta;
    logic [SW-1:0] cnt;

    // Two-flop synchronizer; idles high so nothing looks pressed out of reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta      <= 4'b1111;
            rows_sync <= 4'b1111;
        end else begin
            meta      <= rows;
            rows_sync <= meta;
        end
    end

    // Slot counter, held at zero while scanning is disabled
    always_ff @(posedge clk) begin
        if (!reset_n || !enable) cnt <= '0;
        else if (cnt == LAST)    cnt <= '0;
        else                     cnt <= cnt + 1'b1;
    end

    assign beat = enable && (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce on press and release.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_COUNTS    = 100_000,
    parameter int DEBOUNCE_BEATS = 4,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int            DW      = $clog2(DEBOUNCE_BEATS + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_BEATS - 1);

    if (DEBOUNCE_BEATS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_cfg_bad
        $error("keypad_scanner: beat counts must be at least 1");
    end

    logic [3:0]    rows_s;
    logic          beat;
    logic [1:0]    state, st_n;
    logic [1:0]    col_idx, col_n;
    logic [1:0]    row_lat, row_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [3:0]    code_n;
    logic          valid_n, held_n;
    logic [2:0]    fp;
    logic          lat_pressed;

    keypad_row_sampler #(.SCAN_COUNTS(SCAN_COUNTS)) u_sampler (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .rows      (rows),
        .rows_sync (rows_s),
        .beat      (beat)
    );

    assign fp          = first_pressed(rows_s);
    assign lat_pressed = !rows_s[row_lat];

`ifdef KEYPAD_REPEAT_EN
    localparam int            RW        = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);
    localparam logic [RW-1:0] RD_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RR_LAST   = RW'(REPEAT_RATE - 1);
    logic [RW-1:0] rep_cnt, rep_n;
    logic          rep_arm, arm_n;   // first repeat already issued
`endif

    // Next-state logic; everything advances on beats only
    always_comb begin
        st_n    = state;
        col_n   = col_idx;
        row_n   = row_lat;
        dcnt_n  = dcnt;
        code_n  = key_code;
        valid_n = 1'b0;
        held_n  = key_held;
`ifdef KEYPAD_REPEAT_EN
        rep_n   = rep_cnt;
        arm_n   = rep_arm;
`endif
        if (beat) begin
            case (state)
                ST_SCAN: begin
                    if (fp[2]) begin
                        row_n  = fp[1:0];
                        dcnt_n = '0;
                        st_n   = ST_DEBOUNCE;
                    end else begin
                        col_n = col_idx + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!lat_pressed) begin
                        st_n  = ST_SCAN;
                        col_n = col_idx + 2'd1;
                    end else if (dcnt == DB_LAST) begin
                        st_n    = ST_HELD;
                        dcnt_n  = '0;
                        code_n  = key_lookup(row_lat, col_idx);
                        valid_n = 1'b1;
                        held_n  = 1'b1;
                    end else begin
                        dcnt_n = dcnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!lat_pressed) begin
                        dcnt_n = '0;
                        st_n   = ST_RELEASE;
`ifdef KEYPAD_REPEAT_EN
                        rep_n  = '0;
                        arm_n  = 1'b0;
                    end else if (rep_cnt == (rep_arm ? RR_LAST : RD_LAST)) begin
                        valid_n = 1'b1;
                        rep_n   = '0;
                        arm_n   = 1'b1;
                    end else begin
                        rep_n = rep_cnt + 1'b1;
`endif
                    end
                end
                default: begin // ST_RELEASE
                    if (lat_pressed) begin
                        st_n = ST_HELD;
                    end else if (dcnt == DB_LAST) begin
                        st_n   = ST_SCAN;
                        dcnt_n = '0;
                        held_n = 1'b0;
                        col_n  = col_idx + 2'd1;
                    end else begin
                        dcnt_n = dcnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // State and output registers; disable parks the scanner but keeps key_code
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_SCAN;
            col_idx   <= 2'd0;
            row_lat   <= 2'd0;
            dcnt      <= '0;
            cols      <= COLS_OFF;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else if (!enable) begin
            state     <= ST_SCAN;
            col_idx   <= 2'd0;
            row_lat   <= 2'd0;
            dcnt      <= '0;
            cols      <= COLS_OFF;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= st_n;
            col_idx   <= col_n;
            row_lat   <= row_n;
            dcnt      <= dcnt_n;
            cols      <= COL_PAT[col_n];
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat timer, only runs while in HELD
    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            rep_cnt <= '0;
            rep_arm <= 1'b0;
        end else begin
            rep_cnt <= rep_n;
            rep_arm <= arm_n;
        end
    end
`endif

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameters SHALL be: SCAN_COUNTS, default 100_000, clocks per column slot (1 kHz at 100 MHz); DEBOUNCE_BEATS, default 4, consecutive stable slot ends for press or release; REPEAT_DELAY, default 500, beats before first auto-repeat; REPEAT_RATE, default 100, beats between auto-repeats.
REQ-002 Ports SHALL be:
- clk  input  1  system clock; one clock domain; reset is synchronous and active-low.
- reset_n  input  1  synchronous active-low reset.
- enable  input  1  scan enable.
- rows  input  4  keypad rows, active-low, asynchronous.
- cols  output  4  column strobes, one-hot active-low.
- key_code  output  4  code of the last accepted key.
- key_valid  output  1  one-clock pulse per accepted key.
- key_held  output  1  high while the accepted key is held.

Function
REQ-003 rows SHALL pass through a 2-flop synchronizer before any use.
REQ-004 A slot counter SHALL count 0..SCAN_COUNTS-1 and wrap; the beat is the clock where count = SCAN_COUNTS-1.
REQ-005 cols SHALL cycle 4'b0111, 1011, 1101, 1110, 0111 (column index 0..3, wrapping 3->0), advancing on a beat only in state SCAN.
REQ-006 Rows SHALL be evaluated only on beats; a pressed row is a synchronized bit equal to 0; with several pressed, the lowest row index wins.
REQ-007 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-008 SCAN, beat, any row pressed: latch row and column index, hold column, clear debounce count, go to DEBOUNCE. No row pressed: advance column.
REQ-009 DEBOUNCE, beat, latched row still pressed: increment count; on reaching DEBOUNCE_BEATS go to HELD, load key_code, pulse key_valid for exactly one clock. Latched row released: go to SCAN and advance column.
REQ-010 key_code SHALL be KEY_MAP[row*4+col] (row 0: 1 2 3 A; row 1: 4 5 6 B; row 2: 7 8 9 C; row 3: 0 F E D); key_code holds its value until the next acceptance.
REQ-011 HELD SHALL assert key_held; on a beat with the latched row released, clear count and go to RELEASE.
REQ-012 RELEASE, beat, row released: increment count; on reaching DEBOUNCE_BEATS clear key_held and go to SCAN, advancing column. Row pressed again: return to HELD with no new key_valid.
REQ-013 Presses on other rows or columns SHALL be ignored outside SCAN.
REQ-014 enable low SHALL force cols=4'b1111, state SCAN, column 0, slot counter 0, key_valid 0, key_held 0; key_code is retained.

Reset
REQ-015 Reset SHALL set state SCAN, column 0, slot counter 0, debounce and repeat counters 0, synchronizer flops 4'b1111, cols 4'b1111, key_code 0, key_valid 0, key_held 0.
REQ-016 In the first clock after reset_n rises with enable high, cols SHALL be 4'b0111.
REQ-017 Reset asserted mid-press SHALL abandon the press with no key_valid pulse.

Configuration
REQ-018 Macro KEYPAD_REPEAT_EN defined: in HELD, after REPEAT_DELAY beats, key_valid SHALL pulse again every REPEAT_RATE beats with the same key_code; the counter clears on leaving HELD.
REQ-019 Macro KEYPAD_REPEAT_EN undefined: exactly one key_valid per press; REPEAT_DELAY and REPEAT_RATE are unused.

Structure
REQ-020 Package keypad_pkg SHALL hold the state encoding, the column one-hot patterns and the KEY_MAP table.
REQ-021 The synchronizer plus slot counter SHALL be sub-module keypad_row_sampler, outputting synchronized rows and the beat.

Verification (SCAN_COUNTS=4, DEBOUNCE_BEATS=3, REPEAT_DELAY=5, REPEAT_RATE=2)
REQ-022 Idle after reset, rows=4'b1111 -> cols steps 0111, 1011, 1101, 1110, 0111 every 4 clocks; key_valid never rises.
REQ-023 Row 1 low while column 2 is strobed, held for 10 beats -> exactly one key_valid with key_code=4'h6 on the 3rd stable beat; key_held=1; cols frozen at 1101.
REQ-024 Row 0 low for 1 beat on column 0 (bounce) -> no key_valid; scan resumes at column 1.
REQ-025 Held key released for 2 beats then re-pressed -> key_held stays 1 with no new key_valid; release for 3 beats -> key_held=0 and scan resumes.
REQ-026 Rows 2 and 3 both low on column 3 -> key_code=4'hC.
REQ-027 With KEYPAD_REPEAT_EN defined, key held 12 beats -> key_valid at acceptance, then 5 beats later, then every 2 beats; reset_n low mid-hold -> all outputs reset, no pulse.
